// File: rtl/uart_tx_buffered_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_buffered_pkg
//  Purpose  : Shared FSM encoding, 8N1 frame constants and line-output bundle
//  Revision : 1.0 - initial release
// ============================================================================
package uart_tx_buffered_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE    = 3'd0;
  localparam state_t S_START   = 3'd1;
  localparam state_t S_DATA    = 3'd2;
  localparam state_t S_STOP    = 3'd3;
  localparam state_t S_CLEANUP = 3'd4;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   DATA_BITS = 8;
  localparam int   IDX_W     = $clog2(DATA_BITS);

  typedef logic [DATA_BITS-1:0] uart_byte_t;

  // Registered line outputs travel together so they stay cycle-aligned.
  typedef struct packed {
    logic serial;
    logic active;
    logic done;
  } uart_line_t;

  localparam uart_line_t LINE_IDLE = '{serial: STOP_BIT, active: 1'b0, done: 1'b0};

  function automatic logic in_frame(input state_t state);
    return (state == S_START) || (state == S_DATA) || (state == S_STOP);
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_fifo
//  Purpose  : Synchronous first-word-fall-through byte FIFO for the UART TX path
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo
  import uart_tx_buffered_pkg::*;
#(
  parameter int WIDTH = DATA_BITS,
  parameter int DEPTH = 4
) (
  input  logic                     i_Clock,
  input  logic                     i_Rst_L,
  input  logic                     i_Push,
  input  logic [WIDTH-1:0]         i_Data,
  input  logic                     i_Pop,
  output logic [WIDTH-1:0]         o_Data,
  output logic                     o_Full,
  output logic                     o_Empty,
  output logic [$clog2(DEPTH):0]   o_Count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_DEPTH = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Guards live here too, so a full push or empty pop can never corrupt state.
  assign o_Full  = (r_count == c_DEPTH);
  assign o_Empty = (r_count == '0);
  assign w_push  = i_Push && !o_Full;
  assign w_pop   = i_Pop && !o_Empty;
  assign o_Data  = r_mem[r_rd_ptr];
  assign o_Count = r_count;

  always_ff @(posedge i_Clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_Data;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_buffered
//  Purpose  : 8N1 UART transmitter fed from a small byte FIFO
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_L,
  input  logic                          i_TX_DV,
  input  logic [7:0]                    i_TX_Byte,
  output logic                          o_TX_Ready,
  output logic                          o_TX_Serial,
  output logic                          o_TX_Active,
  output logic                          o_TX_Done,
  output logic                          o_TX_Overrun,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int FC_W  = $clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] c_BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] c_IDX_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [FC_W-1:0]  c_DEPTH    = FC_W'(FIFO_DEPTH);

  logic             r_rst_n;
  state_t           r_state;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [IDX_W-1:0] r_bit_idx;
  uart_byte_t       r_shift;
  uart_line_t       r_line;
  uart_line_t       w_line;
  logic             r_overrun;

  uart_byte_t       w_fifo_data;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [FC_W-1:0]  w_fifo_count;
  logic             w_pop;
  logic             w_bit_end;

  // Reset asserts asynchronously and releases on the next clock edge.
  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      r_rst_n <= 1'b0;
    end else begin
      r_rst_n <= 1'b1;
    end
  end

  assign w_pop     = (r_state == S_IDLE) && !w_fifo_empty;
  assign w_bit_end = (r_clk_cnt == c_BIT_LAST);

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Rst_L (r_rst_n),
    .i_Push  (i_TX_DV),
    .i_Data  (i_TX_Byte),
    .i_Pop   (w_pop),
    .o_Data  (w_fifo_data),
    .o_Full  (w_fifo_full),
    .o_Empty (w_fifo_empty),
    .o_Count (w_fifo_count)
  );

  always_ff @(posedge i_Clock or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
          if (w_pop) begin
            r_shift <= w_fifo_data;
            r_state <= S_START;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == c_IDX_LAST) begin
              r_bit_idx <= '0;
              r_state   <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + IDX_W'(1);
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            r_state   <= S_CLEANUP;
          end else begin
            r_clk_cnt <= r_clk_cnt + CNT_W'(1);
          end
        end
        S_CLEANUP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    w_line        = LINE_IDLE;
    w_line.active = in_frame(r_state);
    case (r_state)
      S_START:   w_line.serial = START_BIT;
      S_DATA:    w_line.serial = r_shift[r_bit_idx];
      S_STOP:    w_line.serial = STOP_BIT;
      S_CLEANUP: w_line.done   = 1'b1;
      default:   w_line.serial = STOP_BIT;
    endcase
  end

  // Outputs lag the state by one cycle, giving the two-edge write-to-start latency.
  always_ff @(posedge i_Clock or negedge r_rst_n) begin
    if (!r_rst_n) begin
      r_line    <= LINE_IDLE;
      r_overrun <= 1'b0;
    end else begin
      r_line    <= w_line;
      r_overrun <= i_TX_DV && w_fifo_full;
    end
  end

  assign o_TX_Serial  = r_line.serial;
  assign o_TX_Active  = r_line.active;
  assign o_TX_Done    = r_line.done;
  assign o_TX_Overrun = r_overrun;
  assign o_FIFO_Count = w_fifo_count;
  assign o_TX_Ready   = (w_fifo_count != c_DEPTH);

endmodule
`default_nettype wire

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 87, clock cycles per serial bit (i_Clock freq / baud); legal range 2..65535.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, byte buffer entries; power of two, legal range 2..16.
REQ-003 SHALL provide port i_Clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL provide port i_Rst_L  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL provide port i_TX_DV  input  1  write strobe; one byte accepted per high cycle when o_TX_Ready=1.
REQ-006 SHALL provide port i_TX_Byte  input  8  byte to transmit, sampled when i_TX_DV=1.
REQ-007 SHALL provide port o_TX_Ready  output  1  high when buffer not full.
REQ-008 SHALL provide port o_TX_Serial  output  1  serial line, idle high.
REQ-009 SHALL provide port o_TX_Active  output  1  high from first start-bit cycle through last stop-bit cycle.
REQ-010 SHALL provide port o_TX_Done  output  1  one-cycle pulse after each completed frame.
REQ-011 SHALL provide port o_TX_Overrun  output  1  one-cycle pulse when a write is dropped.
REQ-012 SHALL provide port o_FIFO_Count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered.

Function
REQ-013 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity; each bit held exactly CLKS_PER_BIT cycles.
REQ-014 FSM states SHALL be IDLE, START, DATA, STOP, CLEANUP.
REQ-015 IDLE: serial high; if buffer non-empty, pop head into shift register, go START; else stay.
REQ-016 START: serial 0; after CLKS_PER_BIT cycles go DATA with bit index 0.
REQ-017 DATA: serial = shift-register bit at index; after CLKS_PER_BIT cycles increment index; after index 7 completes go STOP.
REQ-018 STOP: serial 1; after CLKS_PER_BIT cycles go CLEANUP.
REQ-019 CLEANUP: one cycle, serial 1, o_TX_Done=1, o_TX_Active=0; then IDLE.
REQ-020 Latency: write at edge N into empty buffer with FSM idle -> o_TX_Serial low from edge N+2.
REQ-021 Back-to-back frames SHALL have period exactly 10*CLKS_PER_BIT+2 cycles (CLEANUP + IDLE gap, serial high).
REQ-022 Bit counter width SHALL be $clog2(CLKS_PER_BIT); no wrap within a bit.
REQ-023 o_TX_Ready SHALL equal (o_FIFO_Count != FIFO_DEPTH) combinationally from registered count.
REQ-024 Write while full SHALL be dropped, count unchanged, o_TX_Overrun pulsed next cycle, even if a pop occurs same cycle.
REQ-025 Simultaneous write and pop with buffer non-full SHALL leave count unchanged and preserve FIFO order.
REQ-026 Pop SHALL occur only in IDLE with count>0; empty buffer never popped.
REQ-027 i_TX_Byte changes after acceptance SHALL not affect a buffered or in-flight frame.

Reset
REQ-028 i_Rst_L low SHALL immediately force: FSM IDLE, o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Overrun=0, o_FIFO_Count=0, o_TX_Ready=1, counters and pointers 0.
REQ-029 Reset mid-frame SHALL abort the frame and discard all buffered bytes; no o_TX_Done for the aborted frame.
REQ-030 Deassertion SHALL be synchronized to i_Clock; first write accepted on second edge after release.

Structure
REQ-031 Shared package SHALL hold FSM state encoding (3-bit), frame constants (START_BIT=0, STOP_BIT=1, DATA_BITS=8).
REQ-032 Buffer SHALL be a sub-module uart_tx_fifo (synchronous FIFO, width 8, depth FIFO_DEPTH, push/pop/full/empty/count).

Verification
REQ-033 CLKS_PER_BIT=87, write 0x3F -> serial 0,1,1,1,1,1,1,0,0,1 each 87 cycles; o_TX_Done one pulse at cycle 872 after write.
REQ-034 Write 0xA5 then 0x5A consecutively -> two frames, second start bit exactly 872 cycles after first start bit, LSB first.
REQ-035 FIFO_DEPTH=4, 6 consecutive writes at idle -> 5 accepted (one popped), 6th dropped, o_TX_Ready=0, one o_TX_Overrun pulse, 5 frames sent.
REQ-036 Assert i_Rst_L mid data bit 3 of 0xC3 with 2 bytes buffered -> serial high same cycle, count 0, no Done, line stays idle.
REQ-037 CLKS_PER_BIT=2, stream 0x00,0xFF,0x55 -> each bit exactly 2 cycles, frame period 22 cycles, received bytes match by reference UART receiver model.
